// File: rtl/sw_debounce_ctrl_pkg.sv
// sw_debounce_ctrl_pkg: shared debounce constants and a width helper
package sw_debounce_ctrl_pkg;

    localparam int DEB_100MHZ_10MS = 1000000;
    localparam int DEB_SIM         = 4;

    // Bits needed to hold values 0..v-1; evaluated at elaboration time
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// sw_debounce_bit: one-channel synchroniser and stable-count debouncer
module sw_debounce_bit
    import sw_debounce_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = DEB_100MHZ_10MS
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic commit
);

    localparam int CNT_W = clog2(DEB_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   s;

    assign s      = sync[SYNC_STAGES-1];
    assign commit = (s != dout) && (cnt == CNT_W'(DEB_CYCLES - 1));

    // Shift the raw line through the synchroniser chain
    always_ff @(posedge clock) begin
        if (reset) sync <= '0;
        else       sync <= {sync[SYNC_STAGES-2:0], din};
    end

    // Count consecutive edges that disagree with the accepted level; accept on the last one
    always_ff @(posedge clock) begin
        if (reset) begin
            dout <= 1'b0;
            cnt  <= '0;
        end else if (commit) begin
            dout <= s;
            cnt  <= '0;
        end else begin
            cnt <= (s != dout) ? cnt + CNT_W'(1) : '0;
        end
    end

endmodule

// File: rtl/sw_debounce_ctrl.sv
// sw_debounce_ctrl: debounced switch bank with snapshot handshake and sticky change flags
module sw_debounce_ctrl
    import sw_debounce_ctrl_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = DEB_100MHZ_10MS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_port,
    input  logic [WIDTH-1:0] sw,
    output logic             done_port,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] changed,
    output logic             chg_any
);

    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] commit;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEB_CYCLES (DEB_CYCLES)
        ) u_bit (
            .clock (clock),
            .reset (reset),
            .din   (sw[i]),
            .dout  (deb[i]),
            .commit(commit[i])
        );
    end

    assign chg_any = |changed;

    // Snapshot on start, acknowledge next cycle; a same-edge commit outranks the clear
    always_ff @(posedge clock) begin
        if (reset) begin
            done_port <= 1'b0;
            out1      <= '0;
            changed   <= '0;
        end else begin
            done_port <= start_port;
            out1      <= start_port ? deb : out1;
            changed   <= (start_port ? '0 : changed) | commit;
        end
    end

endmodule
